bit2sym_packer: RTL and testbench
=================================

Name: bit2sym_packer

Overview:
Serial-to-parallel symbol packer that sits directly upstream of the Gray-to-binary mapper stage. It groups an incoming valid/ready bit stream into symbol words of log2(modulation_order) bits. Each word is presented zero-extended to data_width, so it feeds the mapper's i_gray_code input directly. It supports backpressure and end-of-frame flush with zero padding of a partial symbol.

Parameters:
modulation_order, 16, constellation size M; power of two, 2..2^data_width; bits_per_symbol (bps) = $clog2(M)
data_width, 16, output word width; must be >= bps
msb_first, 1, 1: first received bit lands in symbol bit bps-1; 0: first bit lands in bit 0

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
i_bit  input  1  serial data bit
i_valid  input  1  i_bit valid
i_last  input  1  qualifies with i_valid; marks the final bit of a frame
o_ready  output  1  packer accepts a bit this cycle
o_symbol  output  data_width  packed symbol, bits [data_width-1:bps] = 0
o_valid  output  1  o_symbol valid
o_last  output  1  symbol carries the final bit of a frame
i_ready  input  1  downstream accepts o_symbol this cycle

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low. While rst=0 at a clk edge: o_valid=0, o_last=0, o_symbol=0, shift register=0, bit counter=0. Reset dominates all other inputs.
- Elaboration: error if M is not a power of two, if M<2, or if bps>data_width.
- Accept: a bit is accepted when i_valid && o_ready. o_ready = !o_valid || i_ready, combinational from registered o_valid and i_ready only. o_ready never depends on i_valid or i_last.
- Packing, msb_first=1: on accept, shreg <= {shreg[bps-2:0], i_bit} and cnt increments.
- Packing, msb_first=0: on accept, the bit is written at position cnt.
- Completion: the symbol completes when an accepted bit has cnt==bps-1, or an accepted bit has i_last=1. On the next edge:
  - o_symbol loads the completed word.
  - o_valid <= 1; o_last <= i_last.
  - cnt <= 0; shreg <= 0.
- Latency: o_valid rises 1 cycle after the edge that accepts the completing bit.
- Throughput: with i_valid=1 and i_ready=1 continuously, one symbol is produced per bps cycles with no bubbles.
- Partial flush: if i_last is accepted at cnt=k<bps-1, the missing positions are zero.
  - msb_first=1: the collected k+1 bits occupy [bps-1:bps-1-k].
  - msb_first=0: the collected bits occupy [k:0].
- i_last at cnt==bps-1: a full symbol is produced, with o_last=1.
- Output hold: while o_valid=1 and i_ready=0, o_symbol, o_last and o_valid stay stable and o_ready=0.
- Output drain:
  - If i_ready=1 with o_valid=1 and no new completion, o_valid <= 0 and o_last <= 0.
  - If i_ready=1 and a new completion happen in the same cycle, the new word replaces the old one and o_valid stays 1.
- bps=1 (M=2): every accepted bit completes a symbol.
- Reset mid-symbol: partial bits are discarded. The next accepted bit starts a fresh symbol at cnt=0.
- i_last with i_valid=0 is ignored.

Test Plan:
- M=16, msb_first=1, i_ready=1; bits 1,0,1,1 on consecutive cycles -> o_symbol=0x000B, o_valid=1 for one cycle, 1 cycle after the 4th bit is accepted; o_last=0.
- Continuous stream 1,0,1,1,0,1,1,0 with i_ready=1 -> symbols 0x000B then 0x0006, exactly 4 cycles apart, o_ready held 1 throughout.
- Backpressure: complete 0x000B, hold i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0, o_symbol=0x000B held, no bits consumed. Raise i_ready -> next bits resume at cnt=0 with no loss.
- Flush: bits 1,1 with i_last on the 2nd bit -> o_symbol=0x000C, o_last=1. Same input with msb_first=0 -> o_symbol=0x0003, o_last=1.
- Reset mid-symbol: bits 1,1, then rst=0 for 1 cycle, then bits 1,0,0,0 -> o_symbol=0x0008. Outputs read 0 during and immediately after reset.
- msb_first=0, bits 1,0,1,1 -> o_symbol=0x000D. M=2 with bits 1,0 -> o_symbol=0x0001 then 0x0000 on consecutive cycles.

Source files
------------

// File: rtl/bit2sym_if.sv
// Valid/ready bit-stream in, symbol-word stream out, as seen by the bit-to-symbol packer.
interface bit2sym_if #(
  parameter int DATA_W = 16
);
  logic              i_bit;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;
  logic [DATA_W-1:0] o_symbol;
  logic              o_valid;
  logic              o_last;
  logic              i_ready;

  modport slave (
    input  i_bit, i_valid, i_last, i_ready,
    output o_ready, o_symbol, o_valid, o_last
  );

  modport master (
    output i_bit, i_valid, i_last, i_ready,
    input  o_ready, o_symbol, o_valid, o_last
  );
endinterface

// File: rtl/bit2sym_packer.sv
// Packs a serial bit stream into log2(M)-bit symbols, zero-extended to DATA_W,
// with backpressure and zero-padded flush of a partial symbol on i_last.
module bit2sym_packer #(
  parameter int MODULATION_ORDER = 16,
  parameter int DATA_W           = 16,
  parameter bit MSB_FIRST        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  bit2sym_if.slave   bus
);
  localparam int BPS = $clog2(MODULATION_ORDER);
  localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(BPS - 1);

  if (MODULATION_ORDER < 2 || (MODULATION_ORDER & (MODULATION_ORDER - 1)) != 0) begin : g_bad_order
    $error("bit2sym_packer: MODULATION_ORDER must be a power of two >= 2");
  end
  if (BPS > DATA_W) begin : g_bad_width
    $error("bit2sym_packer: DATA_W must be >= log2(MODULATION_ORDER)");
  end
  if ($bits(bus.o_symbol) != DATA_W) begin : g_bad_if
    $error("bit2sym_packer: interface DATA_W does not match module DATA_W");
  end

  function automatic logic [BPS-1:0] insert_bit(input logic [BPS-1:0] sh,
                                                input logic [CW-1:0]  pos,
                                                input logic           b);
    if (MSB_FIRST) return (sh << 1) | BPS'(b);
    else           return sh | (BPS'(b) << pos);
  endfunction

  // MSB-first partial symbols sit low in the shift register; move them to the top.
  function automatic logic [BPS-1:0] align_word(input logic [BPS-1:0] sh,
                                                input logic [CW-1:0]  pos);
    if (MSB_FIRST) return sh << (LAST_POS - pos);
    else           return sh;
  endfunction

  logic [BPS-1:0]    r_shreg_p0;
  logic [CW-1:0]     r_cnt_p0;
  logic [DATA_W-1:0] r_sym_p1;
  logic              r_vld_p1;
  logic              r_last_p1;

  logic              w_ready;
  logic              w_accept;
  logic              w_done;
  logic [BPS-1:0]    w_next;
  logic [BPS-1:0]    w_word;

  assign w_ready  = !r_vld_p1 || bus.i_ready;
  assign w_accept = bus.i_valid && w_ready;
  assign w_done   = w_accept && ((r_cnt_p0 == LAST_POS) || bus.i_last);
  assign w_next   = insert_bit(r_shreg_p0, r_cnt_p0, bus.i_bit);
  assign w_word   = align_word(w_next, r_cnt_p0);

  // Stage p0: bit collection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg_p0 <= '0;
      r_cnt_p0   <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_shreg_p0 <= '0;
        r_cnt_p0   <= '0;
      end else begin
        r_shreg_p0 <= w_next;
        r_cnt_p0   <= r_cnt_p0 + CW'(1);
      end
    end
  end

  // Stage p1: output symbol register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sym_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_done) begin
      r_sym_p1  <= DATA_W'(w_word);
      r_vld_p1  <= 1'b1;
      r_last_p1 <= bus.i_last;
    end else if (bus.i_ready) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end
  end

  assign bus.o_ready  = w_ready;
  assign bus.o_symbol = r_sym_p1;
  assign bus.o_valid  = r_vld_p1;
  assign bus.o_last   = r_last_p1;
endmodule

// File: tb/tb_bit2sym_packer.sv
// Bench for bit2sym_packer: directed scenarios on three configurations plus
// randomized traffic scored against an arithmetic symbol model.
module tb_bit2sym_packer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  // index 0: M=16 MSB-first, 1: M=16 LSB-first, 2: M=2 MSB-first
  logic [2:0] t_bit, t_valid, t_last, t_rdy;

  bit2sym_if #(.DATA_W(16)) if16m ();
  bit2sym_if #(.DATA_W(16)) if16l ();
  bit2sym_if #(.DATA_W(16)) if2 ();

  bit2sym_packer #(.MODULATION_ORDER(16), .DATA_W(16), .MSB_FIRST(1'b1))
    u_m16 (.clk(clk), .rst(rst), .bus(if16m));
  bit2sym_packer #(.MODULATION_ORDER(16), .DATA_W(16), .MSB_FIRST(1'b0))
    u_l16 (.clk(clk), .rst(rst), .bus(if16l));
  bit2sym_packer #(.MODULATION_ORDER(2), .DATA_W(16), .MSB_FIRST(1'b1))
    u_m2 (.clk(clk), .rst(rst), .bus(if2));

  assign if16m.i_bit = t_bit[0];   assign if16m.i_valid = t_valid[0];
  assign if16m.i_last = t_last[0]; assign if16m.i_ready = t_rdy[0];
  assign if16l.i_bit = t_bit[1];   assign if16l.i_valid = t_valid[1];
  assign if16l.i_last = t_last[1]; assign if16l.i_ready = t_rdy[1];
  assign if2.i_bit = t_bit[2];     assign if2.i_valid = t_valid[2];
  assign if2.i_last = t_last[2];   assign if2.i_ready = t_rdy[2];

  wire [2:0] w_rdy = {if2.o_ready, if16l.o_ready, if16m.o_ready};
  wire [2:0] w_vld = {if2.o_valid, if16l.o_valid, if16m.o_valid};
  wire [2:0] w_lst = {if2.o_last, if16l.o_last, if16m.o_last};

  function automatic logic [15:0] sym_of(input int k);
    case (k)
      0:       return if16m.o_symbol;
      1:       return if16l.o_symbol;
      default: return if2.o_symbol;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int k, input logic b, input logic l);
    t_bit[k] = b; t_valid[k] = 1'b1; t_last[k] = l;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    t_valid[k] = 1'b0; t_last[k] = 1'b0;
  endtask

  task automatic settle(input int n);
    t_valid = '0; t_last = '0; t_rdy = '1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; t_valid = '1; t_bit = '1; t_last = '0; t_rdy = '1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (w_vld[k] !== 1'b0 || w_lst[k] !== 1'b0 || sym_of(k) !== 16'h0) begin
        n_err++;
        $display("FAIL reset[%0d]: got vld=%b last=%b sym=%h required 0/0/0000", k, w_vld[k], w_lst[k], sym_of(k));
      end
    end
    t_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    send(0, 1, 0); send(0, 0, 0); send(0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b0) begin n_err++; $display("FAIL single_early: got vld=%b required 0", w_vld[0]); end
    send(0, 1, 0); idle(0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b1 || sym_of(0) !== 16'h000B || w_lst[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single: got vld=%b sym=%h last=%b required 1/000b/0", w_vld[0], sym_of(0), w_lst[0]);
    end
    @(posedge clk); #1; @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b0) begin n_err++; $display("FAIL single_drop: got vld=%b required 0", w_vld[0]); end
  endtask

  task automatic test_stream();
    logic [7:0] pat;
    pat = 8'b10110110;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin t_bit[0] = pat[7-i]; t_valid[0] = 1'b1; end
      else idle(0);
      @(negedge clk);
      if (i < 8) begin
        n_checks++;
        if (w_rdy[0] !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b required 1", i, w_rdy[0]); end
      end
      n_checks++;
      if (w_vld[0] !== ((i == 4) || (i == 8))) begin
        n_err++; $display("FAIL stream_vld[%0d]: got %b required %b", i, w_vld[0], (i == 4) || (i == 8));
      end
      if (i == 4 || i == 8) begin
        n_checks++;
        if (sym_of(0) !== ((i == 4) ? 16'h000B : 16'h0006)) begin
          n_err++; $display("FAIL stream_sym[%0d]: got %h required %h", i, sym_of(0), (i == 4) ? 16'h000B : 16'h0006);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    send(0, 1, 0); send(0, 0, 0); send(0, 1, 0); send(0, 1, 0);
    t_rdy[0] = 1'b0; t_bit[0] = 1'b0; t_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (w_rdy[0] !== 1'b0 || w_vld[0] !== 1'b1 || sym_of(0) !== 16'h000B) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b sym=%h required 0/1/000b", i, w_rdy[0], w_vld[0], sym_of(0));
      end
      @(posedge clk); #1;
    end
    t_rdy[0] = 1'b1;
    send(0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b0) begin n_err++; $display("FAIL bp_drain: got vld=%b required 0", w_vld[0]); end
    send(0, 1, 0); send(0, 1, 0); send(0, 0, 0); idle(0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b1 || sym_of(0) !== 16'h0006) begin
      n_err++; $display("FAIL bp_resume: got vld=%b sym=%h required 1/0006", w_vld[0], sym_of(0));
    end
  endtask

  task automatic test_flush(input int k, input logic [15:0] exp);
    send(k, 1, 0); send(k, 1, 1); idle(k);
    @(negedge clk);
    n_checks++;
    if (w_vld[k] !== 1'b1 || sym_of(k) !== exp || w_lst[k] !== 1'b1) begin
      n_err++;
      $display("FAIL flush[%0d]: got vld=%b sym=%h last=%b required 1/%h/1", k, w_vld[k], sym_of(k), w_lst[k], exp);
    end
  endtask

  task automatic test_reset_mid();
    send(0, 1, 0); send(0, 1, 0); idle(0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b0 || sym_of(0) !== 16'h0 || w_lst[0] !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_out: got vld=%b sym=%h last=%b required 0/0000/0", w_vld[0], sym_of(0), w_lst[0]);
    end
    send(0, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0); idle(0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b1 || sym_of(0) !== 16'h0008) begin
      n_err++; $display("FAIL rst_mid_sym: got vld=%b sym=%h required 1/0008", w_vld[0], sym_of(0));
    end
  endtask

  task automatic test_lsb_first();
    send(1, 1, 0); send(1, 0, 0); send(1, 1, 0); send(1, 1, 0); idle(1);
    @(negedge clk);
    n_checks++;
    if (w_vld[1] !== 1'b1 || sym_of(1) !== 16'h000D || w_lst[1] !== 1'b0) begin
      n_err++; $display("FAIL lsb_first: got vld=%b sym=%h last=%b required 1/000d/0", w_vld[1], sym_of(1), w_lst[1]);
    end
  endtask

  task automatic test_bps1();
    send(2, 1, 0);
    t_bit[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_vld[2] !== 1'b1 || sym_of(2) !== 16'h0001) begin
      n_err++; $display("FAIL bps1_a: got vld=%b sym=%h required 1/0001", w_vld[2], sym_of(2));
    end
    @(posedge clk); #1; idle(2);
    @(negedge clk);
    n_checks++;
    if (w_vld[2] !== 1'b1 || sym_of(2) !== 16'h0000) begin
      n_err++; $display("FAIL bps1_b: got vld=%b sym=%h required 1/0000", w_vld[2], sym_of(2));
    end
  endtask

  task automatic test_last_ignored();
    t_valid[0] = 1'b0; t_last[0] = 1'b1; t_bit[0] = 1'b1;
    @(posedge clk); #1;
    send(0, 0, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); idle(0);
    @(negedge clk);
    n_checks++;
    if (w_vld[0] !== 1'b1 || sym_of(0) !== 16'h0007 || w_lst[0] !== 1'b0) begin
      n_err++; $display("FAIL last_ignored: got vld=%b sym=%h last=%b required 1/0007/0", w_vld[0], sym_of(0), w_lst[0]);
    end
  endtask

  task automatic test_random(input int k, input int bps, input bit msb);
    int          q_sym[$];
    int          q_last[$];
    int          mb[16];
    int          mn;
    int          w;
    int          es, el;
    logic        hold;
    logic [15:0] hold_sym;
    mn = 0; hold = 1'b0; hold_sym = '0;
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    for (int c = 0; c < 700; c++) begin
      if (c < 680) begin
        t_valid[k] = ($urandom_range(0, 3) != 0);
        t_bit[k]   = 1'($urandom_range(0, 1));
        t_last[k]  = ($urandom_range(0, 7) == 0);
        t_rdy[k]   = ($urandom_range(0, 3) != 0);
      end else begin
        idle(k); t_rdy[k] = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (w_rdy[k] !== (!w_vld[k] || t_rdy[k])) begin
        n_err++; $display("FAIL rand_ready[%0d] c=%0d: got %b required %b", k, c, w_rdy[k], !w_vld[k] || t_rdy[k]);
      end
      if (hold) begin
        n_checks++;
        if (w_vld[k] !== 1'b1 || sym_of(k) !== hold_sym) begin
          n_err++; $display("FAIL rand_hold[%0d] c=%0d: got vld=%b sym=%h required 1/%h", k, c, w_vld[k], sym_of(k), hold_sym);
        end
      end
      hold = w_vld[k] && !t_rdy[k];
      hold_sym = sym_of(k);
      if (w_vld[k] && t_rdy[k]) begin
        n_checks++;
        if (q_sym.size() == 0) begin
          n_err++; $display("FAIL rand_extra[%0d] c=%0d: got sym=%h required no symbol", k, c, sym_of(k));
        end else begin
          es = q_sym.pop_front(); el = q_last.pop_front();
          if (sym_of(k) !== 16'(es) || w_lst[k] !== 1'(el)) begin
            n_err++;
            $display("FAIL rand_sym[%0d] c=%0d: got sym=%h last=%b required %h/%0d", k, c, sym_of(k), w_lst[k], es, el);
          end
        end
      end
      if (t_valid[k] && (!w_vld[k] || t_rdy[k])) begin
        mb[mn] = int'(t_bit[k]); mn++;
        if (mn == bps || t_last[k]) begin
          w = 0;
          for (int j = 0; j < mn; j++)
            w += mb[j] * (msb ? (1 << (bps - 1 - j)) : (1 << j));
          q_sym.push_back(w); q_last.push_back(int'(t_last[k]));
          mn = 0;
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (q_sym.size() != 0) begin
      n_err++; $display("FAIL rand_missing[%0d]: got %0d undelivered symbols required 0", k, q_sym.size());
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b0; t_bit = '0; t_valid = '0; t_last = '0; t_rdy = '1;
    test_reset();
    settle(2);
    test_single();      settle(2);
    test_stream();      settle(2);
    test_backpressure(); settle(2);
    test_flush(0, 16'h000C); settle(2);
    test_flush(1, 16'h0003); settle(2);
    test_reset_mid();   settle(2);
    test_lsb_first();   settle(2);
    test_bps1();        settle(2);
    test_last_ignored(); settle(2);
    test_random(0, 4, 1'b1); settle(2);
    test_random(1, 4, 1'b0); settle(2);
    test_random(2, 1, 1'b1); settle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
